imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader that sits upstream of the pipelined core and feeds its instruction memory.
- Accepts a byte stream on a valid/ready interface and packs it into little-endian 32-bit words.
- Writes those words into the instruction-memory write port.
- Holds the core in reset until the whole image is committed, then releases it so the fetch stage starts from the loaded image at word address 0.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  reset; one clock, asynchronous, active-high.
- byte_valid  input  1  upstream byte available.
- byte_data  input  8  upstream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  single-cycle pulse; restarts a load from DONE or ERR.
- imem_we  output  1  instruction-memory write enable.
- imem_addr  output  ADDR_WIDTH  word address.
- imem_wdata  output  32  word data.
- core_reset  output  1  active-high reset to the core.
- done  output  1  image loaded and core released.
- error  output  1  header word count exceeds capacity.
- words_loaded  output  ADDR_WIDTH+1  number of words committed so far.

Behaviour:
- Transfer rule: a byte transfers on a rising edge where byte_valid and byte_ready are both 1.
- Byte packing: bytes pack little-endian; the first byte of a word goes to [7:0] and the fourth to [31:24].
- Byte counter: a 2-bit counter wraps 3->0 on each completed word.
- All registers reset asynchronously. Reset values: state=HDR, byte counter=0, word counter=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, error=0.
- Reset asserted mid-load aborts immediately. Words already written stay in memory; the next load overwrites them.
- States:
  - HDR: byte_ready=1. Collects 4 bytes forming N, the word count (32-bit, little-endian).
    - On the 4th byte: N=0 -> DONE; N>2^ADDR_WIDTH -> ERR; otherwise store N and go to LOAD.
  - LOAD: byte_ready=1. On each 4th byte:
    - imem_we=1 for exactly one cycle, registered.
    - imem_wdata = the packed word; imem_addr = word counter.
    - The word counter increments on the same edge.
    - If this was word N, go to FLUSH.
    - The next word's bytes may be accepted while imem_we is high; there are no bubbles.
  - FLUSH: byte_ready=0. imem_we is high for the final word this cycle. Next edge -> DONE.
  - DONE: byte_ready=0, core_reset=0, done=1. Extra upstream bytes are not consumed.
  - ERR: byte_ready=0, core_reset=1, error=1.
- Exit from DONE/ERR: reload=1 in DONE or ERR goes to HDR on the next edge. That edge also clears the counters, done and error, and sets core_reset=1. reload is ignored in HDR, LOAD and FLUSH.
- Output registration: core_reset, done and error are registered; they change on the edge that enters or leaves DONE/ERR.
- Latency: the last data byte accepted at edge k gives imem_we=1 during cycle k..k+1. The state is DONE and core_reset=0 from edge k+1.
- words_loaded: equals the word counter and is valid in all states. It reaches N in FLUSH and DONE.
- Boundary:
  - N = 2^ADDR_WIDTH is legal. The last address is all-ones and the counter reaches 2^ADDR_WIDTH without wrapping, hence the ADDR_WIDTH+1 width.
  - byte_valid may drop mid-word. The partial word is held indefinitely with no timeout.

Test Plan:
- Bytes 02 00 00 00, 13 00 A0 00, 93 00 10 00 streamed back-to-back:
  - imem writes addr0=0x00A00013 and addr1=0x00100093, each a 1-cycle imem_we.
  - core_reset falls 1 cycle after the last byte; done=1; words_loaded=2.
- Header 00 00 00 00 -> no imem_we ever; DONE entered at the header's 4th byte edge; core_reset=0.
- ADDR_WIDTH=4, header 11 00 00 00 (17 words) -> ERR; error=1; core_reset stays 1; byte_ready=0. Then reload pulse -> HDR; error=0.
- ADDR_WIDTH=4, header N=16 with randomly gapped byte_valid:
  - 16 writes to addrs 0..15 with correct data.
  - Gaps do not corrupt packing; words_loaded=16.
- reset asserted after 5 words of an 8-word load, then released:
  - All outputs return to reset values asynchronously; state=HDR.
  - A fresh 3-word load completes with addrs 0..2.
- After DONE, hold byte_valid=1 -> byte_ready stays 0, no imem_we. Then reload plus a new 1-word image -> core_reset 1 then 0; addr0 holds the new word.

Source files
------------

// File: rtl/imem_loader.sv
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Boot-time loader. Receives a byte stream (32-bit little-endian
//             word count header followed by the image words), writes the image
//             into the instruction memory and holds the core in reset until
//             the whole image is committed.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    // Capacity in words, widened so that the 32-bit header can be compared
    // against it without any truncation.
    localparam logic [32:0]         CAPACITY = 33'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [1:0]          byte_cnt;
    logic [23:0]         acc;        // first three bytes of the word in flight
    logic [ADDR_WIDTH:0] n_words;
    logic [ADDR_WIDTH:0] word_cnt;

    logic                fire;
    logic                word_complete;
    logic [31:0]         word;
    logic                too_big;
    logic                restart;
    logic [ADDR_WIDTH:0] word_cnt_inc;

    // The fourth byte completes the word combinationally, so the word can be
    // written on the very edge that accepts its last byte.
    assign fire          = byte_valid && byte_ready;
    assign word_complete = (byte_cnt == 2'd3);
    assign word          = {byte_data, acc};
    assign too_big       = ({1'b0, word} > CAPACITY);
    assign restart       = reload && ((state == ST_DONE) || (state == ST_ERR));
    assign word_cnt_inc  = word_cnt + CNT_ONE;
    assign words_loaded  = word_cnt;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_HDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the byte_ready handshake.
    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        case (state)
            ST_HDR: begin
                byte_ready = 1'b1;
                if (fire && word_complete) begin
                    if (word == 32'd0) begin
                        state_next = ST_DONE;
                    end else if (too_big) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                byte_ready = 1'b1;
                if (fire && word_complete && (word_cnt_inc == n_words)) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_next = ST_DONE;
            end
            ST_DONE, ST_ERR: begin
                if (reload) begin
                    state_next = ST_HDR;
                end
            end
            default: begin
                state_next = ST_HDR;
            end
        endcase
    end

    // Byte packing, memory write port, counters and registered status flags.
    // The status flags follow the next state so they change on the same edge
    // that enters or leaves DONE/ERR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt   <= 2'd0;
            acc        <= 24'd0;
            n_words    <= '0;
            word_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we    <= 1'b0;
            core_reset <= (state_next != ST_DONE);
            done       <= (state_next == ST_DONE);
            error      <= (state_next == ST_ERR);
            if (restart) begin
                byte_cnt <= 2'd0;
                word_cnt <= '0;
            end else if (fire) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (!word_complete) begin
                    acc <= {byte_data, acc[23:8]};
                end else if (state == ST_LOAD) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                    imem_wdata <= word;
                    word_cnt   <= word_cnt_inc;
                end else begin
                    // Header word; only meaningful when it fits the capacity.
                    n_words <= word[ADDR_WIDTH:0];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader (ADDR_WIDTH = 4, 16 words).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int AW  = 4;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          byte_ready;
    logic          reload = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];        // every write cycle observed on the memory port
    logic [31:0] shadow[CAP];    // memory contents as seen from the port
    logic [31:0] exp_words[$];   // image words of the current load

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .reload       (reload),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Record each write-enable cycle mid-cycle; a one-cycle pulse yields one entry.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_q.push_back('{addr: int'(imem_addr), data: imem_wdata});
            shadow[imem_addr] = imem_wdata;
        end
    end

    // Offer one byte after an idle gap and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (byte_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (byte_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout byte_ready=%b required 1", byte_ready);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    // Send a 32-bit value least-significant byte first.
    task automatic send_word(input logic [31:0] w, input int maxgap);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            send_byte(b, int'($urandom_range(0, maxgap)));
        end
    endtask

    // Build a random image of n words into exp_words.
    task automatic make_image(input int n);
        exp_words.delete();
        for (int i = 0; i < n; i++) exp_words.push_back($urandom);
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        @(posedge clk); #1;
        reset = 1'b0;
        wr_q.delete();
    endtask

    task automatic pulse_reload();
        byte_valid = 1'b0;
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({imem_we, imem_addr, imem_wdata, core_reset, done, error, words_loaded, byte_ready}
            !== {1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values we=%b addr=%h wdata=%h crst=%b done=%b err=%b wl=%0d rdy=%b required 0 0 0 1 0 0 0 1",
                     imem_we, imem_addr, imem_wdata, core_reset, done, error, words_loaded, byte_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        wr_q.delete();
    endtask

    task automatic test_two_words();
        wr_q.delete();
        send_word(32'd2, 0);
        send_word(32'h00A00013, 0);
        send_word(32'h00100093, 0);
        checks++;
        if (imem_we !== 1'b1 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL two_last_byte we=%b crst=%b required 1 1", imem_we, core_reset);
        end
        @(posedge clk); #1;
        checks++;
        if (core_reset !== 1'b0 || done !== 1'b1 || words_loaded !== 5'd2 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL two_done crst=%b done=%b wl=%0d we=%b required 0 1 2 0",
                     core_reset, done, words_loaded, imem_we);
        end
        @(posedge clk); #1;
        checks++;
        if (wr_q.size() != 2) begin
            errors++;
            $display("FAIL two_write_count got=%0d required 2", wr_q.size());
        end else if (wr_q[0].addr != 0 || wr_q[0].data !== 32'h00A00013 ||
                     wr_q[1].addr != 1 || wr_q[1].data !== 32'h00100093) begin
            errors++;
            $display("FAIL two_write_data a0=%0d d0=%h a1=%0d d1=%h required 0 00a00013 1 00100093",
                     wr_q[0].addr, wr_q[0].data, wr_q[1].addr, wr_q[1].data);
        end
    endtask

    task automatic test_zero_header();
        pulse_reset();
        send_word(32'd0, 1);
        checks++;
        if (done !== 1'b1 || core_reset !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_done done=%b crst=%b rdy=%b required 1 0 0", done, core_reset, byte_ready);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() != 0 || words_loaded !== 5'd0) begin
            errors++;
            $display("FAIL zero_no_write writes=%0d wl=%0d required 0 0", wr_q.size(), words_loaded);
        end
    endtask

    task automatic test_overflow();
        pulse_reset();
        send_word(32'd17, 0);
        checks++;
        if (error !== 1'b1 || core_reset !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ovf_err err=%b crst=%b rdy=%b done=%b required 1 1 0 0",
                     error, core_reset, byte_ready, done);
        end
        // A value beyond 32-bit-truncation tricks: upper header bits set.
        repeat (3) @(posedge clk);
        #1;
        pulse_reload();
        checks++;
        if (error !== 1'b0 || byte_ready !== 1'b1 || core_reset !== 1'b1 || words_loaded !== 5'd0) begin
            errors++;
            $display("FAIL ovf_reload err=%b rdy=%b crst=%b wl=%0d required 0 1 1 0",
                     error, byte_ready, core_reset, words_loaded);
        end
        send_word(32'h0001_0001, 0);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL ovf_high_bits err=%b required 1", error);
        end
    endtask

    task automatic test_full_gapped();
        int bad;
        pulse_reset();
        make_image(CAP);
        send_word(32'(CAP), 3);
        for (int i = 0; i < CAP; i++) send_word(exp_words[i], 3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || words_loaded !== 5'(CAP) || core_reset !== 1'b0) begin
            errors++;
            $display("FAIL full_done done=%b wl=%0d crst=%b required 1 %0d 0",
                     done, words_loaded, core_reset, CAP);
        end
        checks++;
        bad = -1;
        if (wr_q.size() == CAP) begin
            for (int i = 0; i < CAP; i++)
                if (bad < 0 && (wr_q[i].addr != i || wr_q[i].data !== exp_words[i])) bad = i;
        end
        if (wr_q.size() != CAP || bad >= 0) begin
            errors++;
            $display("FAIL full_writes count=%0d first_bad=%0d required count %0d all matching",
                     wr_q.size(), bad, CAP);
        end
    endtask

    task automatic test_reset_midload();
        pulse_reset();
        make_image(8);
        send_word(32'd8, 1);
        for (int i = 0; i < 5; i++) send_word(exp_words[i], 1);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({imem_we, imem_addr, imem_wdata, core_reset, done, error, words_loaded, byte_ready}
            !== {1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL midload_reset we=%b addr=%h wdata=%h crst=%b done=%b err=%b wl=%0d rdy=%b required 0 0 0 1 0 0 0 1",
                     imem_we, imem_addr, imem_wdata, core_reset, done, error, words_loaded, byte_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        wr_q.delete();
        make_image(3);
        send_word(32'd3, 0);
        for (int i = 0; i < 3; i++) send_word(exp_words[i], 0);
        @(posedge clk); #1;
        checks++;
        if (wr_q.size() != 3 || done !== 1'b1 || words_loaded !== 5'd3) begin
            errors++;
            $display("FAIL midload_fresh writes=%0d done=%b wl=%0d required 3 1 3",
                     wr_q.size(), done, words_loaded);
        end else if (wr_q[0].addr != 0 || wr_q[0].data !== exp_words[0] ||
                     wr_q[1].addr != 1 || wr_q[1].data !== exp_words[1] ||
                     wr_q[2].addr != 2 || wr_q[2].data !== exp_words[2]) begin
            errors++;
            $display("FAIL midload_fresh_data a0=%0d a1=%0d a2=%0d required 0 1 2 with image data",
                     wr_q[0].addr, wr_q[1].addr, wr_q[2].addr);
        end
    endtask

    task automatic test_done_hold_reload();
        logic [31:0] nw;
        int          rdy_bad;
        // Still in DONE from the previous load; keep offering bytes.
        wr_q.delete();
        rdy_bad = 0;
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            if (byte_ready !== 1'b0) rdy_bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (rdy_bad != 0 || wr_q.size() != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold ready_cycles=%0d writes=%0d done=%b required 0 0 1",
                     rdy_bad, wr_q.size(), done);
        end
        pulse_reload();
        checks++;
        if (core_reset !== 1'b1 || done !== 1'b0 || words_loaded !== 5'd0) begin
            errors++;
            $display("FAIL reload_state crst=%b done=%b wl=%0d required 1 0 0",
                     core_reset, done, words_loaded);
        end
        nw = $urandom;
        send_word(32'd1, 2);
        send_word(nw, 2);
        @(posedge clk); #1;
        checks++;
        if (core_reset !== 1'b0 || done !== 1'b1 || shadow[0] !== nw || wr_q.size() != 1) begin
            errors++;
            $display("FAIL reload_image crst=%b done=%b mem0=%h writes=%0d required 0 1 %h 1",
                     core_reset, done, shadow[0], wr_q.size(), nw);
        end
    endtask

    // Reload must be ignored while a load is in progress.
    task automatic test_reload_ignored();
        pulse_reset();
        make_image(2);
        send_word(32'd2, 0);
        send_byte(exp_words[0][7:0], 0);
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        send_byte(exp_words[0][15:8], 0);
        send_byte(exp_words[0][23:16], 0);
        send_byte(exp_words[0][31:24], 0);
        send_word(exp_words[1], 0);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || wr_q.size() != 2 || words_loaded !== 5'd2) begin
            errors++;
            $display("FAIL reload_ignored done=%b writes=%0d wl=%0d required 1 2 2",
                     done, wr_q.size(), words_loaded);
        end else if (wr_q[0].data !== exp_words[0] || wr_q[1].data !== exp_words[1]) begin
            errors++;
            $display("FAIL reload_ignored_data d0=%h d1=%h required %h %h",
                     wr_q[0].data, wr_q[1].data, exp_words[0], exp_words[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < CAP; i++) shadow[i] = 32'd0;
        @(posedge clk); #1;
        test_reset();
        test_two_words();
        test_zero_header();
        test_overflow();
        test_full_gapped();
        test_reset_midload();
        test_done_hold_reload();
        test_reload_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
